// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants, output-stage states and lowest-index helper
package enc_pkg;

   localparam int NUM_IN = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   // Lowest set index wins; an all-zero vector yields 0.
   function automatic logic [CODE_W-1:0] lsb_index(input logic [0:NUM_IN-1] v);
      lsb_index = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (v[i]) lsb_index = CODE_W'(i);
      end
   endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// rtl/prio_enc_8_3.sv - combinational lowest-index priority encoder
module prio_enc_8_3
   import enc_pkg::*;
(
   input  logic [0:7] req,
   output logic [2:0] code,
   output logic       any
);

   assign code = lsb_index(req);
   assign any  = |req;

endmodule

// File: rtl/enc_8_3_evt.sv
// rtl/enc_8_3_evt.sv - event-driven 8-to-3 encoder with pending queue and valid/ready output
module enc_8_3_evt
   import enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:7] d,
   input  logic       En,
   output logic [2:0] a,
   output logic       valid,
   input  logic       ready,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       busy
);

   out_state_t state;
   out_state_t state_nxt;
   logic [0:7] d_q;
   logic [0:7] pending;
   logic [0:7] rise;
   logic [0:7] take;
   logic [2:0] code;
   logic       any;
   logic       load;
   logic       grant;

   prio_enc_8_3 u_prio (
      .req  (pending),
      .code (code),
      .any  (any)
   );

   // d_q tracks d even while disabled so re-enabling cannot fire a stale edge.
   assign rise = d & ~d_q & {8{En}};
   assign busy = (|pending) | valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q     <= '0;
         pending <= '0;
         ovf     <= 1'b0;
      end else begin
         d_q     <= d;
         pending <= (pending & ~take) | rise;
         if (|(rise & pending & ~take)) ovf <= 1'b1;
         else if (ovf_clr)              ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      load      = (state == ST_EMPTY) || ready;
      state_nxt = state;
      if (load) state_nxt = any ? ST_FULL : ST_EMPTY;
   end

   always_comb begin
      valid = (state == ST_FULL);
      grant = load && any;
      take  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         take[i] = grant && (code == CODE_W'(i));
      end
   end

   // The code holds its last value when the slot drains empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     a <= '0;
      else if (grant) a <= code;
   end

endmodule

// File: tb/tb_enc_8_3_evt.sv
// tb/tb_enc_8_3_evt.sv - self-checking bench for enc_8_3_evt
module tb_enc_8_3_evt;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:7] d;
   logic       En;
   logic [2:0] a;
   logic       valid;
   logic       ready;
   logic       ovf;
   logic       ovf_clr;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int got[$];

   logic [0:7] m_dq, m_pend, mn_pend, mn_take, mn_rise;
   logic       m_valid, mn_valid, m_ovf, mn_ovf;
   logic [2:0] m_a, mn_a;
   int         m_first;

   always #5 clk = ~clk;

   enc_8_3_evt dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (d),
      .En      (En),
      .a       (a),
      .valid   (valid),
      .ready   (ready),
      .ovf     (ovf),
      .ovf_clr (ovf_clr),
      .busy    (busy)
   );

   // Reference: a set of waiting events plus one output slot.
   always_comb begin
      mn_rise  = d & ~m_dq & {8{En}};
      mn_take  = '0;
      mn_valid = m_valid;
      mn_a     = m_a;
      m_first  = -1;
      if (!m_valid || ready) begin
         for (int i = 7; i >= 0; i--) if (m_pend[i]) m_first = i;
         if (m_first >= 0) begin
            mn_valid         = 1'b1;
            mn_a             = 3'(m_first);
            mn_take[m_first] = 1'b1;
         end else begin
            mn_valid = 1'b0;
         end
      end
      mn_ovf = m_ovf;
      if (ovf_clr) mn_ovf = 1'b0;
      if ((mn_rise & m_pend & ~mn_take) != 8'h00) mn_ovf = 1'b1;
      mn_pend = (m_pend & ~mn_take) | mn_rise;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dq <= '0; m_pend <= '0; m_valid <= 1'b0; m_a <= '0; m_ovf <= 1'b0;
      end else begin
         m_dq <= d; m_pend <= mn_pend; m_valid <= mn_valid; m_a <= mn_a; m_ovf <= mn_ovf;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected codes packed one per nibble, first emitted in the lowest nibble.
   task automatic chk_seq(input string name, input int n, input logic [31:0] exp);
      chk({name, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], int'(exp[4*i +: 4]));
      got.delete();
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_a", a, m_a);
      chk("cmp_valid", valid, m_valid);
      chk("cmp_ovf", ovf, m_ovf);
      chk("cmp_busy", busy, int'((m_pend != 8'h00) || m_valid));
      if (valid && ready) got.push_back(int'(a));
   end

   initial begin
      rst_n = 1'b0; d = 8'hFF; En = 1'b1; ready = 1'b1; ovf_clr = 1'b0;
      step(3);
      chk("rst_a", a, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step(12);
      chk_seq("t1_order", 8, 32'h7654_3210);

      d = '0; step(3);
      d[5] = 1'b1; step(2);
      chk("t2_valid", valid, 1);
      chk("t2_a", a, 5);
      step(1);
      chk("t2_valid_drop", valid, 0);
      chk("t2_busy_drop", busy, 0);
      chk_seq("t2_seq", 1, 32'h5);

      d = '0; step(2);
      d[1] = 1'b1; d[3] = 1'b1; d[6] = 1'b1; step(6);
      chk_seq("t3_burst", 3, 32'h631);
      chk("t3_valid_end", valid, 0);

      d = '0; ready = 1'b0; step(2);
      d[2] = 1'b1; d[5] = 1'b1; step(2);
      for (int k = 0; k < 5; k++) begin
         chk("t4_hold_a", a, 2);
         chk("t4_hold_valid", valid, 1);
         step(1);
      end
      ready = 1'b1; step(1);
      chk("t4_next_a", a, 5);
      chk("t4_next_valid", valid, 1);
      step(1);
      chk("t4_end_valid", valid, 0);
      chk_seq("t4_seq", 2, 32'h52);

      ready = 1'b0; d = '0; step(2);
      d[0] = 1'b1; step(1);
      d = '0; step(2);
      chk("t5_slot_a", a, 0);
      d[4] = 1'b1; step(1);
      d[4] = 1'b0; step(1);
      chk("t5_ovf_first", ovf, 0);
      d[4] = 1'b1; step(1);
      chk("t5_ovf_set", ovf, 1);
      d[4] = 1'b0; ready = 1'b1; step(4);
      chk_seq("t5_seq", 2, 32'h40);
      chk("t5_ovf_sticky", ovf, 1);
      ovf_clr = 1'b1; step(1);
      ovf_clr = 1'b0;
      chk("t5_ovf_clr", ovf, 0);

      En = 1'b0; d = '0; step(2);
      d[7] = 1'b1; step(4);
      chk("t6_dis_busy", busy, 0);
      En = 1'b1; step(3);
      chk("t6_reen_busy", busy, 0);
      chk_seq("t6_dis_seq", 0, 32'h0);

      d = '0; ready = 1'b0; step(2);
      d[0] = 1'b1; step(1);
      d = '0; step(2);
      d[2] = 1'b1; step(1);
      d[2] = 1'b0; step(1);
      d[2] = 1'b1; ready = 1'b1; step(1);
      d[2] = 1'b0; step(4);
      chk_seq("t6_collide", 3, 32'h220);
      chk("t6_collide_ovf", ovf, 0);

      ready = 1'b0; d = '0; step(2);
      d[3] = 1'b1; d[6] = 1'b1; step(3);
      d = '0; step(1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", valid, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_a", a, 0);
      rst_n = 1'b1;
      step(3);
      chk("t7_after_busy", busy, 0);
      chk_seq("t7_seq", 0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
